an_tx_balance_seq: RTL and testbench
====================================

// Module: an_tx_balance_seq
// PURPOSE
//  Sequencer that drives AN_TX BUS_BALANCEs. Sweeps the balance code as a triangle wave (0->max->0), one step per dwell period.
//  The push switch starts, pauses and resumes the sweep. A JTAG override source wins over the sweep.
//  Sits in CQ_MAX10_TOP between PSWs_i[0] / JTAG_DBGER source bits and AN_TX.BUS_BALANCEs_i.
// PARAMETERS
//  C_CK_Fs          135_000_000  CK_i frequency [Hz]
//  C_BAL_W          6            balance code width
//  C_DWELL_MS       500          dwell per step [ms]
//  C_DEB_MS         10           switch debounce time [ms]
//  C_SIM_DWELL_CKN  0            if nonzero, overrides dwell length in CK cycles
//  C_SIM_DEB_CKN    0            if nonzero, overrides debounce length in CK cycles
// PORTS
//  CK_i            in   1        clock
//  ARST_i          in   1        async reset, active-high
//  PSW_i           in   1        push switch, active-high, asynchronous, bouncing
//  OVR_i           in   1        JTAG override enable (quasi-static, async)
//  OVR_BALs_i      in   C_BAL_W  JTAG override code
//  BUS_BALANCEs_o  out  C_BAL_W  code to AN_TX
//  RUN_o           out  1        1 while in RUN_UP/RUN_DN
//  STEP_o          out  1        1-cycle pulse on each sweep code change
//  OVR_ACT_o       out  1        1 while output follows override
// BEHAVIOUR
//  Reset values: BUS_BALANCEs_o = all ones, RUN_o = 0, STEP_o = 0, OVR_ACT_o = 0, state = IDLE, counters = 0, SEQ code = all ones.
//  Input sync: PSW_i and OVR_i each pass through a 2-FF synchroniser.
//  Debounce: the filtered level changes only after the synced input has been stable for N_DEB cycles.
//   - N_DEB = C_SIM_DEB_CKN ? C_SIM_DEB_CKN : C_CK_Fs/1000*C_DEB_MS.
//   - PRESS = 1-cycle pulse on the filtered rising edge. A held switch gives exactly one PRESS.
//  Dwell: N_DW = C_SIM_DWELL_CKN ? C_SIM_DWELL_CKN : C_CK_Fs/1000*C_DWELL_MS.
//   - Counter runs only in RUN_*. It clears on every step and on entering RUN_*.
//   - DW_END = counter == N_DW-1.
//  FSM (SEQ = internal sweep code, MAX = 2^C_BAL_W-1):
//   IDLE   : PRESS -> RUN_UP, SEQ=0, STEP pulse.
//   RUN_UP : DW_END & SEQ<MAX -> SEQ+1 ; DW_END & SEQ==MAX -> RUN_DN, SEQ=MAX-1. STEP on each change.
//   RUN_DN : DW_END & SEQ>0 -> SEQ-1 ; DW_END & SEQ==0 -> RUN_UP, SEQ=1. STEP on each change.
//   HOLD_U/HOLD_D : entered from RUN_UP/RUN_DN on PRESS; SEQ is frozen.
//   - Next PRESS returns to the same direction with the dwell counter cleared.
//  Simultaneous PRESS and DW_END in RUN_*: PRESS wins, no step, go to HOLD_*.
//  Override (synced OVR=1):
//   - FSM and dwell counter freeze.
//   - PRESS pulses are discarded.
//   - BUS_BALANCEs_o <= OVR_BALs_i, registered. Override data is taken as quasi-static (not resynchronised).
//   - OVR_ACT_o=1, STEP_o=0.
//   - On OVR drop, output returns to SEQ the next cycle and the FSM resumes exactly where it froze.
//  Output otherwise: BUS_BALANCEs_o = SEQ (registered). Latency: SEQ change and STEP_o appear in the same cycle.
//  RUN_o = state in {RUN_UP, RUN_DN}, registered. RUN_o=1 while frozen in RUN_* under override.
//  Reset mid-sweep: all outputs return to reset values immediately (async).
//   - The first PRESS after release restarts at SEQ=0.
//  Width rules: counters are sized with log2(N+1). No arithmetic wraps; the ends are handled by FSM turn-around only.
// STRUCTURE
//  Shared include an_tx_pkg.vh: FSM state encodings (IDLE, RUN_UP, RUN_DN, HOLD_U, HOLD_D), log2 function, ms->CK-count macro.
//  One sub-module: psw_debounce (2-FF sync + stable counter + rising-edge pulse).
//   - Instanced once for PSW_i. OVR_i uses only a 2-FF sync.
//  Top integration: CQ_MAX10_TOP ties PSW_i=~XPSW_i, OVR_i=BJ_DBGs[6], OVR_BALs_i=BJ_DBGs[5:0], ARST_i=~XARST.
// TESTING  (C_BAL_W=3, C_SIM_DEB_CKN=4, C_SIM_DWELL_CKN=8)
//  1 Reset release, no press for 100 cycles -> BUS_BALANCEs_o=7, RUN_o=0, STEP_o never pulses.
//  2 PSW_i held high 50 cycles -> exactly one PRESS. Sweep 0,1,...,7,6,...,0,1 with codes changing every 8 cycles, one STEP_o per change; RUN_o=1.
//  3 PSW_i toggling every 2 cycles for 20 cycles (bounce), then 0 -> no PRESS, state unchanged.
//  4 Press while at SEQ=5 in RUN_DN -> frozen at 5 for 40 cycles, RUN_o=0.
//     Second press -> 4 appears 8 cycles after resume, then 3.
//  5 OVR_i=1, OVR_BALs_i=2 while sweeping at SEQ=3:
//     - output=2 after sync + 1 cycle; OVR_ACT_o=1; presses ignored.
//     - After OVR_i=0: output=3, next step to 4 after a full dwell.
//  6 ARST_i pulsed mid-sweep -> outputs=reset values immediately.
//     Next press restarts at 0. Also cover PRESS coincident with DW_END -> HOLD, no step.

Source files
------------

// File: rtl/an_tx_balance_seq_pkg.sv
// Shared types and helpers for the AN_TX balance sequencer.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package an_tx_balance_seq_pkg;

  // Sweep sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN_UP = 3'd1,
    ST_RUN_DN = 3'd2,
    ST_HOLD_U = 3'd3,
    ST_HOLD_D = 3'd4
  } seq_st_t;

  // Ceiling log2; counters that must hold 0..N are sized f_log2(N+1)
  function automatic int f_log2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Milliseconds to clock cycles for a clock of fs_hz
  function automatic int f_ms2ck(input int fs_hz, input int ms);
    return (fs_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/an_tx_balance_seq_psw_debounce.sv
// Push-switch conditioner: 2-FF sync, stability filter, one-cycle pulse on filtered rise.
// Latency: PRESS is asserted 2 + N_DEB cycles after a clean input rising edge.
// Backpressure: none; the pulse is single-cycle and is not held for the consumer.
module an_tx_balance_seq_psw_debounce
  import an_tx_balance_seq_pkg::*;
#(
  parameter int N_DEB = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_press
);

  localparam int                W_DEB  = f_log2(N_DEB + 1);
  localparam logic [W_DEB-1:0]  C_LAST = W_DEB'(N_DEB - 1);
  localparam logic [W_DEB-1:0]  C_ONE  = W_DEB'(1);

  logic             r_s1;
  logic             r_s2;
  logic             r_level;
  logic             r_press;
  logic [W_DEB-1:0] r_cnt;
  logic             w_done;

  // The synced input has differed from the filtered level for N_DEB cycles in a row
  assign w_done = (r_s2 != r_level) && (r_cnt == C_LAST);

  // Two-stage synchroniser for the asynchronous, bouncing switch
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
    end
  end

  // Stability counter; any glitch back to the current level restarts the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= w_done && r_s2;
      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_done) begin
        r_level <= r_s2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + C_ONE;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/an_tx_balance_seq.sv
// Triangle-sweep sequencer for AN_TX bus balance, push-switch start/pause, JTAG override.
// Latency: code and STEP_o change together one cycle after the step decision; override 3 cycles after OVR_i.
// Backpressure: none; free-running, the consumer samples the code level directly.
module an_tx_balance_seq
  import an_tx_balance_seq_pkg::*;
#(
  parameter int C_CK_Fs         = 135_000_000,
  parameter int C_BAL_W         = 6,
  parameter int C_DWELL_MS      = 500,
  parameter int C_DEB_MS        = 10,
  parameter int C_SIM_DWELL_CKN = 0,
  parameter int C_SIM_DEB_CKN   = 0
) (
  input  logic               CK_i,
  input  logic               ARST_i,
  input  logic               PSW_i,
  input  logic               OVR_i,
  input  logic [C_BAL_W-1:0] OVR_BALs_i,
  output logic [C_BAL_W-1:0] BUS_BALANCEs_o,
  output logic               RUN_o,
  output logic               STEP_o,
  output logic               OVR_ACT_o
);

  localparam int N_DEB = (C_SIM_DEB_CKN != 0) ? C_SIM_DEB_CKN : f_ms2ck(C_CK_Fs, C_DEB_MS);
  localparam int N_DW  = (C_SIM_DWELL_CKN != 0) ? C_SIM_DWELL_CKN : f_ms2ck(C_CK_Fs, C_DWELL_MS);
  localparam int W_DW  = f_log2(N_DW + 1);

  localparam logic [W_DW-1:0]    C_DW_LAST = W_DW'(N_DW - 1);
  localparam logic [W_DW-1:0]    C_DW_ONE  = W_DW'(1);
  localparam logic [C_BAL_W-1:0] C_MAX     = '1;
  localparam logic [C_BAL_W-1:0] C_ONE     = C_BAL_W'(1);

  seq_st_t              r_state;
  logic [C_BAL_W-1:0]   r_seq;
  logic [W_DW-1:0]      r_dw_cnt;
  logic                 r_step;
  logic                 r_run;
  logic                 r_ovr_act;
  logic [C_BAL_W-1:0]   r_bal;
  logic                 r_ovr_s1;
  logic                 r_ovr_s2;

  seq_st_t              w_state_nxt;
  logic [C_BAL_W-1:0]   w_seq_nxt;
  logic [W_DW-1:0]      w_dw_nxt;
  logic                 w_step_nxt;
  logic                 w_press;
  logic                 w_ovr;
  logic                 w_dw_end;

  an_tx_balance_seq_psw_debounce #(
    .N_DEB (N_DEB)
  ) u_psw_deb (
    .i_clk   (CK_i),
    .i_rst   (ARST_i),
    .i_async (PSW_i),
    .o_press (w_press)
  );

  // Override enable is only resynchronised; the override code is quasi-static
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_ovr_s1 <= 1'b0;
      r_ovr_s2 <= 1'b0;
    end else begin
      r_ovr_s1 <= OVR_i;
      r_ovr_s2 <= r_ovr_s1;
    end
  end

  assign w_ovr    = r_ovr_s2;
  assign w_dw_end = (r_dw_cnt == C_DW_LAST);

  // Next-state: override freezes everything; a press outranks a dwell expiry
  always_comb begin
    w_state_nxt = r_state;
    w_seq_nxt   = r_seq;
    w_dw_nxt    = r_dw_cnt;
    w_step_nxt  = 1'b0;
    if (!w_ovr) begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            w_state_nxt = ST_RUN_UP;
            w_seq_nxt   = '0;
            w_dw_nxt    = '0;
            w_step_nxt  = 1'b1;
          end
        end
        ST_RUN_UP: begin
          if (w_press) begin
            w_state_nxt = ST_HOLD_U;
          end else if (w_dw_end) begin
            w_dw_nxt   = '0;
            w_step_nxt = 1'b1;
            if (r_seq == C_MAX) begin
              w_state_nxt = ST_RUN_DN;
              w_seq_nxt   = C_MAX - C_ONE;
            end else begin
              w_seq_nxt = r_seq + C_ONE;
            end
          end else begin
            w_dw_nxt = r_dw_cnt + C_DW_ONE;
          end
        end
        ST_RUN_DN: begin
          if (w_press) begin
            w_state_nxt = ST_HOLD_D;
          end else if (w_dw_end) begin
            w_dw_nxt   = '0;
            w_step_nxt = 1'b1;
            if (r_seq == '0) begin
              w_state_nxt = ST_RUN_UP;
              w_seq_nxt   = C_ONE;
            end else begin
              w_seq_nxt = r_seq - C_ONE;
            end
          end else begin
            w_dw_nxt = r_dw_cnt + C_DW_ONE;
          end
        end
        ST_HOLD_U: begin
          if (w_press) begin
            w_state_nxt = ST_RUN_UP;
            w_dw_nxt    = '0;
          end
        end
        ST_HOLD_D: begin
          if (w_press) begin
            w_state_nxt = ST_RUN_DN;
            w_dw_nxt    = '0;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_seq_nxt   = C_MAX;
          w_dw_nxt    = '0;
        end
      endcase
    end
  end

  // State and output registers; code output is taken from next-SEQ so it aligns with STEP_o
  always_ff @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      r_state   <= ST_IDLE;
      r_seq     <= C_MAX;
      r_dw_cnt  <= '0;
      r_step    <= 1'b0;
      r_run     <= 1'b0;
      r_ovr_act <= 1'b0;
      r_bal     <= C_MAX;
    end else begin
      r_state   <= w_state_nxt;
      r_seq     <= w_seq_nxt;
      r_dw_cnt  <= w_dw_nxt;
      r_step    <= w_step_nxt;
      r_run     <= (w_state_nxt == ST_RUN_UP) || (w_state_nxt == ST_RUN_DN);
      r_ovr_act <= w_ovr;
      r_bal     <= w_ovr ? OVR_BALs_i : w_seq_nxt;
    end
  end

  assign BUS_BALANCEs_o = r_bal;
  assign RUN_o          = r_run;
  assign STEP_o         = r_step;
  assign OVR_ACT_o      = r_ovr_act;

endmodule

// File: tb/tb_an_tx_balance_seq.sv
// Bench for the balance sequencer: sweep-position model compared every cycle plus literal pins.
// Latency: n/a.
// Backpressure: n/a.
module tb_an_tx_balance_seq;

  localparam int BW   = 3;
  localparam int DEB  = 4;
  localparam int DW   = 8;
  localparam int MAXV = (1 << BW) - 1;

  logic          CK_i       = 1'b0;
  logic          ARST_i     = 1'b0;
  logic          PSW_i      = 1'b0;
  logic          OVR_i      = 1'b0;
  logic [BW-1:0] OVR_BALs_i = '0;
  logic [BW-1:0] BUS_BALANCEs_o;
  logic          RUN_o;
  logic          STEP_o;
  logic          OVR_ACT_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  an_tx_balance_seq #(
    .C_BAL_W         (BW),
    .C_SIM_DEB_CKN   (DEB),
    .C_SIM_DWELL_CKN (DW)
  ) dut (
    .CK_i           (CK_i),
    .ARST_i         (ARST_i),
    .PSW_i          (PSW_i),
    .OVR_i          (OVR_i),
    .OVR_BALs_i     (OVR_BALs_i),
    .BUS_BALANCEs_o (BUS_BALANCEs_o),
    .RUN_o          (RUN_o),
    .STEP_o         (STEP_o),
    .OVR_ACT_o      (OVR_ACT_o)
  );

  always #5 CK_i = ~CK_i;

  // ---------------- behavioural model ----------------
  // Sweep position is a step count p; the code is a triangle function of p.
  bit          m_p1 = 0, m_p2 = 0, m_o1 = 0, m_o2 = 0, m_lvl = 0, m_press = 0;
  int          m_diff_run = 0;
  bit          m_started = 0, m_running = 0, m_step = 0, m_ovr_act = 0;
  int          m_p = 0, m_el = 0;
  logic [BW-1:0] m_bal = '1;

  function automatic int tri_code(input int p);
    int k;
    k = p % (2 * MAXV);
    return (k <= MAXV) ? k : (2 * MAXV - k);
  endfunction

  always @(posedge CK_i or posedge ARST_i) begin
    if (ARST_i) begin
      m_p1 = 0; m_p2 = 0; m_o1 = 0; m_o2 = 0; m_lvl = 0; m_press = 0; m_diff_run = 0;
      m_started = 0; m_running = 0; m_step = 0; m_ovr_act = 0; m_p = 0; m_el = 0;
      m_bal = '1;
    end else begin
      m_step = 0;
      if (!m_o2) begin
        if (!m_started) begin
          if (m_press) begin
            m_started = 1; m_running = 1; m_p = 0; m_el = 0; m_step = 1;
          end
        end else if (m_running) begin
          if (m_press) m_running = 0;
          else if (m_el == DW - 1) begin m_p++; m_el = 0; m_step = 1; end
          else m_el++;
        end else if (m_press) begin
          m_running = 1; m_el = 0;
        end
      end
      m_bal     = m_o2 ? OVR_BALs_i : (m_started ? BW'(tri_code(m_p)) : BW'(MAXV));
      m_ovr_act = m_o2;
      // switch path: level flips after the synced value has differed DEB times in a row
      m_press = 0;
      if (m_p2 != m_lvl) begin
        m_diff_run++;
        if (m_diff_run == DEB) begin
          m_lvl = m_p2; m_diff_run = 0; m_press = m_lvl;
        end
      end else begin
        m_diff_run = 0;
      end
      m_p2 = m_p1; m_p1 = PSW_i;
      m_o2 = m_o1; m_o1 = OVR_i;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge CK_i) begin
    if (chk_en) begin
      n_checks++;
      if (BUS_BALANCEs_o === m_bal && RUN_o === (m_started && m_running) &&
          STEP_o === m_step && OVR_ACT_o === m_ovr_act) begin
        n_pass++;
      end else begin
        $display("FAIL cycle_cmp t=%0t bal=%0d/%0d run=%0b/%0b step=%0b/%0b ovr_act=%0b/%0b (dut/model)",
                 $time, BUS_BALANCEs_o, m_bal, RUN_o, (m_started && m_running),
                 STEP_o, m_step, OVR_ACT_o, m_ovr_act);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic cyc();
    @(negedge CK_i);
  endtask

  task automatic wait_step(input int lim, output int v, output int n);
    bit got;
    got = 0; v = -1; n = 0;
    for (int i = 0; i < lim && !got; i++) begin
      cyc();
      n++;
      if (STEP_o) begin
        got = 1;
        v = int'(BUS_BALANCEs_o);
      end
    end
    chk_eq("step_seen", int'(got), 1);
  endtask

  task automatic wait_run(input int lim);
    bit got;
    got = 0;
    for (int i = 0; i < lim && !got; i++) begin
      cyc();
      if (RUN_o) got = 1;
    end
    chk_eq("run_seen", int'(got), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int exp_sw [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int v, n, prev, steps, nonovr, ret;
  bit ok_h, got;

  initial begin
    #2 ARST_i = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) cyc();
    ARST_i = 1'b0;
    chk_eq("rst_bal", int'(BUS_BALANCEs_o), MAXV);
    chk_eq("rst_run", int'(RUN_o), 0);
    chk_eq("rst_step", int'(STEP_o), 0);
    chk_eq("rst_ovr_act", int'(OVR_ACT_o), 0);

    // 1: idle, no press
    steps = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (STEP_o) steps++;
    end
    chk_eq("idle_steps", steps, 0);
    chk_eq("idle_bal", int'(BUS_BALANCEs_o), MAXV);
    chk_eq("idle_run", int'(RUN_o), 0);

    // 2: held press gives a single start, then a full triangle sweep
    fork
      begin
        PSW_i = 1'b1;
        repeat (50) cyc();
        PSW_i = 1'b0;
      end
    join_none
    for (int i = 0; i < 16; i++) begin
      wait_step(40, v, n);
      chk_eq($sformatf("sweep_code%0d", i), v, exp_sw[i]);
      if (i > 0) chk_eq($sformatf("sweep_gap%0d", i), n, DW);
    end
    chk_eq("sweep_run", int'(RUN_o), 1);

    // 3: bounce shorter than the filter window
    for (int i = 0; i < 10; i++) begin
      PSW_i = ~PSW_i;
      cyc();
      cyc();
    end
    PSW_i = 1'b0;
    repeat (10) cyc();
    chk_eq("bounce_run", int'(RUN_o), 1);

    // 4: pause at 5 on the way down, then resume
    prev = -1;
    for (int i = 0; i < 14; i++) begin
      wait_step(20, v, n);
      if (prev == 6 && v == 5) break;
      prev = v;
    end
    chk_eq("find5dn", v, 5);
    PSW_i = 1'b1;
    repeat (8) cyc();
    PSW_i = 1'b0;
    ok_h = 1;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (BUS_BALANCEs_o != 3'd5 || RUN_o || STEP_o) ok_h = 0;
    end
    chk_eq("hold_frozen", int'(ok_h), 1);
    chk_eq("hold_code", int'(BUS_BALANCEs_o), 5);
    chk_eq("hold_run", int'(RUN_o), 0);
    PSW_i = 1'b1;
    wait_run(20);
    PSW_i = 1'b0;
    wait_step(20, v, n);
    chk_eq("resume_code", v, 4);
    chk_eq("resume_gap", n, DW);
    wait_step(20, v, n);
    chk_eq("resume_code2", v, 3);
    chk_eq("resume_gap2", n, DW);

    // 5: override while at 3 on the way up
    prev = 3;
    for (int i = 0; i < 12; i++) begin
      wait_step(20, v, n);
      if (prev == 2 && v == 3) break;
      prev = v;
    end
    chk_eq("find3up", v, 3);
    OVR_BALs_i = 3'd2;
    OVR_i      = 1'b1;
    nonovr     = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (!OVR_ACT_o) nonovr++;
      if (i == 1) chk_eq("ovr_sync_lat", int'(BUS_BALANCEs_o), 3);
    end
    chk_eq("ovr_code", int'(BUS_BALANCEs_o), 2);
    chk_eq("ovr_act", int'(OVR_ACT_o), 1);
    PSW_i = 1'b1;
    repeat (10) cyc();
    PSW_i = 1'b0;
    repeat (15) cyc();
    chk_eq("ovr_press_ign_code", int'(BUS_BALANCEs_o), 2);
    chk_eq("ovr_run_frozen", int'(RUN_o), 1);
    OVR_i = 1'b0;
    ret = -1; got = 0; v = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      cyc();
      if (!OVR_ACT_o) begin
        nonovr++;
        if (ret < 0) ret = int'(BUS_BALANCEs_o);
      end
      if (STEP_o) begin
        got = 1;
        v = int'(BUS_BALANCEs_o);
      end
    end
    chk_eq("ovr_return_code", ret, 3);
    chk_eq("ovr_next_step", v, 4);
    chk_eq("ovr_dwell_total", nonovr, DW);

    // press landing exactly on the dwell expiry: hold, no step
    cyc();
    PSW_i = 1'b1;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (i == 8) PSW_i = 1'b0;
      if (STEP_o) steps++;
    end
    chk_eq("coinc_steps", steps, 0);
    chk_eq("coinc_code", int'(BUS_BALANCEs_o), 4);
    chk_eq("coinc_run", int'(RUN_o), 0);

    // 6: resume, then async reset mid-sweep
    repeat (12) cyc();
    PSW_i = 1'b1;
    wait_run(20);
    PSW_i = 1'b0;
    wait_step(20, v, n);
    chk_eq("coinc_resume_code", v, 5);
    repeat (3) cyc();
    #2 ARST_i = 1'b1;
    #1;
    chk_eq("arst_bal", int'(BUS_BALANCEs_o), MAXV);
    chk_eq("arst_run", int'(RUN_o), 0);
    chk_eq("arst_step", int'(STEP_o), 0);
    chk_eq("arst_ovr_act", int'(OVR_ACT_o), 0);
    repeat (3) cyc();
    ARST_i = 1'b0;
    repeat (10) cyc();
    chk_eq("post_rst_bal", int'(BUS_BALANCEs_o), MAXV);
    chk_eq("post_rst_run", int'(RUN_o), 0);
    PSW_i = 1'b1;
    wait_step(20, v, n);
    chk_eq("restart_code", v, 0);
    PSW_i = 1'b0;
    repeat (10) cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
